hex_scan_driver: RTL and testbench

- Time-multiplexed scanner for the board's 8-digit seven-segment display. Sits directly upstream of the 4-bit hex-to-segment decoder.
- Takes a 32-bit debug word from the single-cycle CPU (PC, ALU result, register value), snapshots it once per frame, and walks the digits one at a time.
- Each slot presents one nibble to the decoder and drives the matching active-low digit anode.
- Optional leading-zero blanking.

---
 rtl/hex_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_hex_scan_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_driver.sv
// hex_scan_driver
//   Time-multiplexed scanner for a multi-digit seven-segment display. A data
//   word is captured once per frame. The digits are then lit one per slot,
//   each slot lasting DIV clock cycles. Each slot presents one nibble to the
//   downstream hex-to-segment decoder and pulls the matching anode low.
//   Leading zero digits can optionally be blanked. Digit 0 is never blanked.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   data_in     value to display, nibble i = data_in[4i+3:4i], digit 0 = LSN
//   hold        1 = keep the current snapshot at the frame wrap
//   nibble_out  nibble for the active digit (decoder input)
//   an_out      active-low one-hot digit enable, all ones = dark
//   blank_out   1 = current slot blanked
//   frame_done  one-cycle pulse after the scan wraps to digit 0
module hex_scan_driver #(
  parameter int DIGITS   = 8,
  parameter int DIV      = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  hold,
  output logic [3:0]            nibble_out,
  output logic [DIGITS-1:0]     an_out,
  output logic                  blank_out,
  output logic                  frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRE_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [IW-1:0]     IDX_ZERO = {IW{1'b0}};
  localparam logic [DIGITS-1:0] AN_DARK  = {DIGITS{1'b1}};
  localparam logic [DIGITS-1:0] AN_ONE   = {{(DIGITS-1){1'b0}}, 1'b1};

  // Bit i is set when nibbles i..DIGITS-1 of v are all zero. Digit i is then
  // a leading zero, unless i is digit 0.
  function automatic logic [DIGITS-1:0] zero_tail(input logic [4*DIGITS-1:0] v);
    logic [DIGITS-1:0] z;
    logic              run;
    z   = {DIGITS{1'b0}};
    run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run  = run & (v[4*i +: 4] == 4'h0);
      z[i] = run;
    end
    return z;
  endfunction

  logic [PW-1:0]         prescale_r;
  logic [IW-1:0]         idx_r;
  logic [4*DIGITS-1:0]   snap_r;
  logic [3:0]            nibble_r;
  logic [DIGITS-1:0]     an_r;
  logic                  blank_r;
  logic                  frame_done_r;

  logic                  tick_s;
  logic                  wrap_s;
  logic [IW-1:0]         idx_n_s;
  logic [4*DIGITS-1:0]   snap_n_s;
  logic [DIGITS-1:0]     tail_zero_s;
  logic                  blank_n_s;
  logic [3:0]            nibble_n_s;
  logic [DIGITS-1:0]     an_n_s;

  // Next-state view of the scan: the index, snapshot and slot outputs that
  // become valid after this edge if the edge is a tick.
  always_comb begin
    tick_s      = (prescale_r == PRE_LAST);
    idx_n_s     = idx_r;
    snap_n_s    = snap_r;
    blank_n_s   = 1'b1;
    nibble_n_s  = 4'h0;
    an_n_s      = AN_DARK;

    if (tick_s) begin
      if (idx_r == IDX_LAST) begin
        idx_n_s = IDX_ZERO;
      end else begin
        idx_n_s = idx_r + IW'(1);
      end
    end else begin
      idx_n_s = idx_r;
    end

    wrap_s = tick_s && (idx_n_s == IDX_ZERO);

    // hold is only looked at on the wrap tick, so a frame is never torn.
    if (wrap_s && !hold) begin
      snap_n_s = data_in;
    end else begin
      snap_n_s = snap_r;
    end

    // Blanking uses the snapshot as it will be after this edge. The first
    // slot of a new frame therefore already sees the freshly loaded word.
    tail_zero_s = zero_tail(snap_n_s);
    blank_n_s   = (LZ_BLANK != 0) && (idx_n_s != IDX_ZERO) && tail_zero_s[idx_n_s];

    if (blank_n_s) begin
      an_n_s     = AN_DARK;
      nibble_n_s = 4'h0;
    end else begin
      an_n_s     = ~(AN_ONE << idx_n_s);
      nibble_n_s = snap_n_s[{idx_n_s, 2'b00} +: 4];
    end
  end

  // Slot prescaler: counts 0..DIV-1 and returns to zero on the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_r <= {PW{1'b0}};
    end else if (tick_s) begin
      prescale_r <= {PW{1'b0}};
    end else begin
      prescale_r <= prescale_r + PW'(1);
    end
  end

  // Scan state: the digit index and the frame snapshot advance only on a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r  <= IDX_ZERO;
      snap_r <= {(4*DIGITS){1'b0}};
    end else if (tick_s) begin
      idx_r  <= idx_n_s;
      snap_r <= snap_n_s;
    end else begin
      idx_r  <= idx_r;
      snap_r <= snap_r;
    end
  end

  // Registered display outputs: these are held stable between ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nibble_r <= 4'h0;
      an_r     <= AN_DARK;
      blank_r  <= 1'b1;
    end else if (tick_s) begin
      nibble_r <= nibble_n_s;
      an_r     <= an_n_s;
      blank_r  <= blank_n_s;
    end else begin
      nibble_r <= nibble_r;
      an_r     <= an_r;
      blank_r  <= blank_r;
    end
  end

  // Frame pulse: high for the single cycle that follows the wrap tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= wrap_s;
    end
  end

  assign nibble_out = nibble_r;
  assign an_out     = an_r;
  assign blank_out  = blank_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Testbench for hex_scan_driver.
//   dut_a (DIV=4, LZ_BLANK=1): a directed slot sequence is pushed into a queue.
//     A monitor pops one entry each time a slot update is due and checks the
//     outputs. It also checks that the outputs stay stable between ticks.
//   dut_b (DIV=4, LZ_BLANK=0, data 0): all digits lit, showing 0.
//   dut_c (DIV=1, LZ_BLANK=1): the scan runs every cycle, checked against a
//     small per-cycle model.
module tb_hex_scan_driver;

  typedef struct packed {
    logic [3:0] nib;
    logic [7:0] an;
    logic       blank;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_a, data_b, data_c;
  logic        hold_a, hold_b, hold_c;
  logic [3:0]  nib_a, nib_b, nib_c;
  logic [7:0]  an_a, an_b, an_c;
  logic        blank_a, blank_b, blank_c;
  logic        fd_a, fd_b, fd_c;

  int   errors = 0;
  int   checks = 0;
  int   cyc_a;
  exp_t exp_q[$];
  exp_t last_exp;

  logic [3:0] s1_nib [8] = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
  logic [7:0] s1_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  always #5 clk = ~clk;

  hex_scan_driver #(.DIGITS(8), .DIV(4), .LZ_BLANK(1)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .hold(hold_a),
    .nibble_out(nib_a), .an_out(an_a), .blank_out(blank_a), .frame_done(fd_a));

  hex_scan_driver #(.DIGITS(8), .DIV(4), .LZ_BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .hold(hold_b),
    .nibble_out(nib_b), .an_out(an_b), .blank_out(blank_b), .frame_done(fd_b));

  hex_scan_driver #(.DIGITS(8), .DIV(1), .LZ_BLANK(1)) dut_c (
    .clk(clk), .rst(rst), .data_in(data_c), .hold(hold_c),
    .nibble_out(nib_c), .an_out(an_c), .blank_out(blank_c), .frame_done(fd_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Queue the expected outputs for the next tick, then wait until that tick has passed.
  task automatic step(input logic [3:0] n, input logic [7:0] a, input logic b, input logic f);
    exp_t e;
    e.nib   = n;
    e.an    = a;
    e.blank = b;
    e.fd    = f;
    exp_q.push_back(e);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic blanks(input int count);
    for (int i = 0; i < count; i++) step(4'h0, 8'hFF, 1'b1, 1'b0);
  endtask

  // Count cycles since dut_a last left reset. The monitor uses this count to
  // find the slot boundaries.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc_a <= 0;
    else     cyc_a <= cyc_a + 1;
  end

  // Monitor for dut_a. At each tick it takes the next entry from the queue.
  // Between ticks it checks that the outputs have not moved.
  always @(negedge clk) begin
    if (rst) begin
      last_exp = {4'h0, 8'hFF, 1'b1, 1'b0};
    end else if (cyc_a > 0 && (cyc_a % 4) == 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL slot_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        last_exp = exp_q.pop_front();
        check("slot", 32'({nib_a, an_a, blank_a, fd_a}), 32'(last_exp));
      end
    end else if (cyc_a > 0) begin
      check("stable", 32'({nib_a, an_a, blank_a, fd_a}),
            32'({last_exp.nib, last_exp.an, last_exp.blank, 1'b0}));
    end
  end

  // dut_b model: with blanking off and data 0, every slot is lit and shows 0.
  initial begin
    logic [7:0] one;
    exp_t       e;
    int         k;
    int         idx;
    one = 8'h01;
    @(negedge rst);
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      k = n / 4;
      if (k == 0) begin
        e = {4'h0, 8'hFF, 1'b1, 1'b0};
      end else begin
        idx     = k % 8;
        e.nib   = 4'h0;
        e.an    = ~(one << idx);
        e.blank = 1'b0;
        e.fd    = ((n % 4) == 0) && (idx == 0);
      end
      check("lz_off", 32'({nib_b, an_b, blank_b, fd_b}), 32'(e));
    end
  end

  // dut_c model: DIV=1, so the index advances every cycle.
  initial begin
    logic [7:0] one;
    exp_t       e;
    int         idx;
    one = 8'h01;
    @(negedge rst);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      idx = n % 8;
      if (n < 8) begin
        e = {4'h0, 8'hFF, 1'b1, 1'b0};
      end else begin
        e.nib   = data_c[4*idx +: 4];
        e.an    = ~(one << idx);
        e.blank = 1'b0;
        e.fd    = (idx == 0);
      end
      check("div1", 32'({nib_c, an_c, blank_c, fd_c}), 32'(e));
      check("div1_onehot", 32'($countones(~an_c) <= 1), 32'(1));
    end
  end

  // Directed stimulus for dut_a.
  initial begin
    rst    = 1'b1;
    data_a = 32'h1234_ABCD;
    hold_a = 1'b0;
    data_b = 32'h0000_0000;
    hold_b = 1'b0;
    data_c = 32'h8765_4321;
    hold_c = 1'b0;
    #3;
    check("rst_nib",   32'(nib_a),   32'h0);
    check("rst_an",    32'(an_a),    32'hFF);
    check("rst_blank", 32'(blank_a), 32'h1);
    check("rst_fd",    32'(fd_a),    32'h0);
    #19 rst = 1'b0;

    // Scenario 1: the first frame is dark. Digit 0 lights at the 8th tick.
    // The data changes mid-frame but must not disturb this frame.
    blanks(7);
    for (int i = 0; i < 8; i++) begin
      step(s1_nib[i], s1_an[i], 1'b0, (i == 0));
      if (i == 1) data_a = 32'h0000_00A0;
    end

    // Scenario 2: leading zero blanking with A0, then with all zeros.
    step(4'h0, 8'hFE, 1'b0, 1'b1);
    step(4'hA, 8'hFD, 1'b0, 1'b0);
    data_a = 32'h0000_0000;
    blanks(6);
    step(4'h0, 8'hFE, 1'b0, 1'b1);
    data_a = 32'h0000_0055;
    blanks(7);

    // Scenario 4: hold freezes 55 across one wrap, then the released hold
    // lets FFFF_FFFF through at the next wrap.
    step(4'h5, 8'hFE, 1'b0, 1'b1);
    step(4'h5, 8'hFD, 1'b0, 1'b0);
    hold_a = 1'b1;
    data_a = 32'hFFFF_FFFF;
    blanks(6);
    step(4'h5, 8'hFE, 1'b0, 1'b1);
    step(4'h5, 8'hFD, 1'b0, 1'b0);
    hold_a = 1'b0;
    blanks(6);
    for (int i = 0; i < 6; i++) step(4'hF, s1_an[i], 1'b0, (i == 0));

    // Scenario 6: an asynchronous reset arrives at idx = 5, in the middle of a cycle.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_nib",   32'(nib_a),   32'h0);
    check("async_an",    32'(an_a),    32'hFF);
    check("async_blank", 32'(blank_a), 32'h1);
    check("async_fd",    32'(fd_a),    32'h0);
    check("queue_drained_at_rst", 32'(exp_q.size()), 32'h0);
    data_a = 32'h1234_ABCD;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    blanks(7);
    for (int i = 0; i < 8; i++) step(s1_nib[i], s1_an[i], 1'b0, (i == 0));
    repeat (2) @(negedge clk);
    check("queue_drained_at_end", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
